// File: rtl/rca_nibble_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rca_nibble_sequencer_pkg
// Description : Shared state encoding and slice width for the nibble-serial
//               add/subtract unit.
// Revision    : 1.0  initial release
// ============================================================================
package rca_nibble_sequencer_pkg;

  // Width of the shared ripple-carry slice.
  localparam int NIBBLE_W = 4;

  // Control states; encoding 2'd3 is unused and recovers to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage : rca_nibble_sequencer_pkg
`default_nettype wire

// File: rtl/rca_nibble_sequencer_rca4.sv
`default_nettype none
// ============================================================================
// Module      : rca_nibble_sequencer_rca4
// Description : Purely combinational 4-bit ripple-carry adder slice. Also
//               exposes the carry into its top bit so the caller can form
//               signed overflow on the most significant nibble.
// Revision    : 1.0  initial release
// ============================================================================
module rca_nibble_sequencer_rca4
  import rca_nibble_sequencer_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                c_i,
  output logic [NIBBLE_W-1:0] s_o,
  output logic                c_o,
  output logic                c_msb_o
);

  // Internal carry chain: w_c[k] is the carry into bit k.
  logic [NIBBLE_W:0] w_c;

  assign w_c[0] = c_i;

  genvar gi;
  generate
    for (gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
      assign s_o[gi]    = a_i[gi] ^ b_i[gi] ^ w_c[gi];
      assign w_c[gi+1]  = (a_i[gi] & b_i[gi]) | (w_c[gi] & (a_i[gi] ^ b_i[gi]));
    end
  endgenerate

  assign c_o     = w_c[NIBBLE_W];
  assign c_msb_o = w_c[NIBBLE_W-1];

endmodule : rca_nibble_sequencer_rca4
`default_nettype wire

// File: rtl/rca_nibble_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rca_nibble_sequencer
// Description : Multi-cycle WIDTH-bit add/subtract unit. One 4-bit ripple
//               slice is time-shared, one nibble per clock, LSB first, with
//               a carry register linking consecutive nibbles. Operands enter
//               on a valid/ready handshake, the result leaves on another.
// Revision    : 1.0  initial release
// ============================================================================
module rca_nibble_sequencer
  import rca_nibble_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;

  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_s_nib;
  logic                w_slice_cout;
  logic                w_slice_cmsb;

  // Select the operand nibbles addressed by the current index.
  always_comb begin
    w_a_nib = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    w_b_nib = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
  end

  // The single shared adder slice.
  rca_nibble_sequencer_rca4 u_rca4 (
    .a_i     (w_a_nib),
    .b_i     (w_b_nib),
    .c_i     (carry_q),
    .s_o     (w_s_nib),
    .c_o     (w_slice_cout),
    .c_msb_o (w_slice_cmsb)
  );

  // Next-state and datapath update: accept in IDLE, one nibble per RUN cycle,
  // hold the result in DONE until the consumer takes it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1; cin flips the implied +1 into a borrow-in.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = cin ^ sub;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = w_s_nib;
        carry_d = w_slice_cout;
        if (idx_q == IDX_LAST) begin
          // Overflow compares the carry into the MSB with the carry out of it.
          cout_d  = w_slice_cout;
          ovf_d   = w_slice_cmsb ^ w_slice_cout;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule : rca_nibble_sequencer
`default_nettype wire

// File: tb/tb_rca_nibble_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rca_nibble_sequencer
// Description : Directed testbench for rca_nibble_sequencer (WIDTH=16).
//               A driver pushes hand-computed expectations into a queue; a
//               monitor pops one whenever out_valid rises and compares.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rca_nibble_sequencer;

  localparam int WIDTH = 16;
  localparam int NIB   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  rca_nibble_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               acc;
    string            name;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  // Monitor: on every rising out_valid, compare against the oldest expectation.
  // Latency: DONE is registered on the NIB-th edge after the accept edge
  // (NIB+1 clocks counting the accept edge itself).
  logic prev_v = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rst_n && out_valid && !prev_v) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_sum"},     32'(sum),  32'(e.sum));
        check({e.name, "_cout"},    32'(cout), 32'(e.cout));
        check({e.name, "_ovf"},     32'(ovf),  32'(e.ovf));
        check({e.name, "_latency"}, 32'(cyc - e.acc), 32'(NIB));
      end
    end
    prev_v = out_valid;
  end

  // Drive one operand request; optionally record the expected result.
  task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                       input logic ic, input logic is, input logic push,
                       input logic [WIDTH-1:0] es, input logic ec, input logic ev,
                       input string nm);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    a = ia; b = ib; cin = ic; sub = is; in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check({nm, "_accept_timeout"}, 32'd0, 32'd1);
    end else if (push) begin
      e.sum = es; e.cout = ec; e.ovf = ev; e.acc = cyc + 1; e.name = nm;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  // Wait until all expectations are consumed and the unit is idle again.
  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((sb.size() != 0 || !in_ready) && t < 60) begin
      @(negedge clk);
      t++;
    end
    check({nm, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_sum",       32'(sum),       32'h0);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_cout_ovf",  32'({cout, ovf}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'h1);

    // Basic add, full ripple, signed overflow cases, subtraction, borrow-in.
    issue(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, "add_basic");
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "add_ripple");
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, "add_posovf");
    issue(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, "add_negovf");
    issue(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_neg");
    issue(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, "sub_pos");
    issue(16'h1000, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h0FFE, 1'b1, 1'b0, "sub_borrowin");
    drain("group1");

    // Back-pressure: result must stay frozen while out_ready is low.
    out_ready = 1'b0;
    issue(16'h00FF, 16'h0F01, 1'b1, 1'b0, 1'b1, 16'h1001, 1'b0, 1'b0, "bp_op");
    begin
      int t;
      t = 0;
      while (!out_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      a = 16'($urandom); b = 16'($urandom);
      check("bp_out_valid", 32'(out_valid), 32'h1);
      check("bp_in_ready",  32'(in_ready),  32'h0);
      check("bp_frozen",    32'({sum, cout, ovf}), 32'({16'h1001, 1'b0, 1'b0}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_out_valid", 32'(out_valid), 32'h0);
    check("bp_release_in_ready",  32'(in_ready),  32'h1);
    drain("bp");

    // Asynchronous reset two clocks into RUN: op is lost, outputs clear at once.
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, "lost_op");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sum",       32'(sum),       32'h0);
    check("arst_cout_ovf",  32'({cout, ovf}), 32'h0);
    check("arst_out_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("arst_no_output", 32'(out_valid), 32'h0);
    issue(16'hABCD, 16'h1111, 1'b1, 1'b0, 1'b1, 16'hBCDF, 1'b0, 1'b0, "post_reset");
    drain("post_reset");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_rca_nibble_sequencer
`default_nettype wire
